// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with RUN/HALT/EXC control, redirect priority and misalignment faults.
// Optional return-address stack is compiled in only when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer #(
  parameter int unsigned         NB_WIDTH     = 32,
  parameter logic [NB_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [NB_WIDTH-1:0] EXC_VECTOR   = NB_WIDTH'(32'h80),
  parameter int unsigned         STEP         = 4,
  parameter int unsigned         RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_halt,
  input  logic                i_resume,
  input  logic                i_stall,
  input  logic                i_exc,
  input  logic                i_jump_valid,
  input  logic [NB_WIDTH-1:0] i_jump_addr,
  input  logic                i_branch_valid,
  input  logic [NB_WIDTH-1:0] i_branch_addr,
  input  logic                i_call,
  input  logic [NB_WIDTH-1:0] i_link_addr,
  input  logic                i_ret,
  output logic [NB_WIDTH-1:0] o_pcounter,
  output logic [NB_WIDTH-1:0] o_pcounter4,
  output logic                o_valid,
  output logic [1:0]          o_state,
  output logic [NB_WIDTH-1:0] o_epc,
  output logic                o_misaligned,
  output logic [3:0]          o_ras_count
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    EXC  = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [NB_WIDTH-1:0] pc_q, pc_d;
  logic [NB_WIDTH-1:0] epc_q, epc_d;
  logic                mis_q, mis_d;

  logic [NB_WIDTH-1:0] ras_top;
  logic                ras_hit;
  logic [NB_WIDTH-1:0] target;
  logic                redirect;
  logic                fault;
  logic                advance;

  assign o_pcounter   = pc_q;
  assign o_pcounter4  = pc_q + NB_WIDTH'(STEP);
  assign o_valid      = (state_q == RUN);
  assign o_state      = state_q;
  assign o_epc        = epc_q;
  assign o_misaligned = mis_q;

  always_comb begin
    redirect = 1'b1;
    target   = o_pcounter4;
    if (ras_hit) begin
      target = ras_top;
    end else if (i_jump_valid) begin
      target = i_jump_addr;
    end else if (i_branch_valid) begin
      target = i_branch_addr;
    end else begin
      redirect = 1'b0;
    end
  end

  assign fault = redirect && (target[1:0] != 2'b00);

  // advance marks a normal RUN step; stack updates are gated on it
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    mis_d   = 1'b0;
    advance = 1'b0;
    case (state_q)
      RUN: begin
        if (i_exc) begin
          pc_d    = EXC_VECTOR;
          epc_d   = pc_q;
          state_d = EXC;
        end else if (i_halt) begin
          state_d = HALT;
        end else if (!i_stall) begin
          if (fault) begin
            pc_d    = EXC_VECTOR;
            epc_d   = target;
            mis_d   = 1'b1;
            state_d = EXC;
          end else begin
            pc_d    = target;
            advance = 1'b1;
          end
        end
      end
      HALT: begin
        if (!i_halt && i_resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mis_q   <= mis_d;
    end
  end

`ifdef PC_SEQUENCER_RAS_EN
  // Entry 0 is the top; a push shifts toward the bottom and drops the oldest when full
  logic [NB_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [NB_WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [3:0]          cnt_q, cnt_d;
  logic                push, pop;

  assign ras_top     = ras_q[0];
  assign ras_hit     = i_ret && (cnt_q != '0);
  assign push        = advance && i_call;
  assign pop         = advance && ras_hit;
  assign o_ras_count = cnt_q;

  always_comb begin
    ras_d = ras_q;
    cnt_d = cnt_q;
    if (push && pop) begin
      ras_d[0] = i_link_addr;
    end else if (push) begin
      for (int unsigned i = RAS_DEPTH - 1; i > 0; i--) ras_d[i] = ras_q[i-1];
      ras_d[0] = i_link_addr;
      if (cnt_q != 4'(RAS_DEPTH)) cnt_d = cnt_q + 4'd1;
    end else if (pop) begin
      for (int unsigned i = 0; i < RAS_DEPTH - 1; i++) ras_d[i] = ras_q[i+1];
      ras_d[RAS_DEPTH-1] = '0;
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      ras_q <= ras_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_ras;

  assign ras_top     = '0;
  assign ras_hit     = 1'b0;
  assign o_ras_count = '0;
  assign unused_ras  = ^{i_call, i_ret, i_link_addr, advance, 4'(RAS_DEPTH)};
`endif

endmodule
